// File: rtl/shop_cmd_assembler.sv
// ---------------------------------------------------------------------------
// shop_cmd_assembler
//
// Front end of the shop command FSM. It splits a raw ASCII byte stream into
// tokens separated by whitespace or newlines, then presents each token as a
// right-aligned packed string together with its decimal value.
//
// Byte classes:
//   terminator : 0x20, 0x0A, 0x0D
//   printable  : 0x21..0x7E
//   illegal    : everything else
//
// A token is discarded, and o_err pulses, if it is longer than
// I_A_NUM_ASCII_CHARS or if it contains an illegal byte. Empty tokens, such as
// repeated separators, are ignored.
//
// Ports:
//   i_clk      clock
//   i_reset    synchronous, active-high reset
//   i_valid    i_byte is valid this cycle
//   i_byte     ASCII character
//   o_ready    a byte is accepted when i_valid & o_ready
//              (low during reset and in the EMIT and ERR cycles)
//   o_rdy      one-cycle pulse: a new token is on o_a/o_u/o_u_valid
//   o_a        token string, right-aligned, zero-padded on the left
//   o_u        numeric value of the token (0 when not a valid number)
//   o_u_valid  token was all digits and fits in o_u
//   o_err      one-cycle pulse: token discarded
//
// o_a, o_u and o_u_valid are loaded on the edge that enters EMIT. They hold
// their values until the next EMIT, so they are already stable while o_rdy
// is high.
// ---------------------------------------------------------------------------
module shop_cmd_assembler #(
    parameter int I_A_NUM_ASCII_CHARS = 7,
    parameter int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
    parameter int I_U_NUM_BITS        = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [7:0]              i_byte,
    output logic                    o_ready,
    output logic                    o_rdy,
    output logic [I_A_NUM_BITS-1:0] o_a,
    output logic [I_U_NUM_BITS-1:0] o_u,
    output logic                    o_u_valid,
    output logic                    o_err
);

    // The accumulator has 4 bits of headroom over o_u. Each product is
    // formed 4 bits wider again, so acc*10+9 can never wrap before it is
    // compared against the limit.
    localparam int ACC_W = I_U_NUM_BITS + 4;
    localparam int RES_W = ACC_W + 4;
    localparam int CNT_W = $clog2(I_A_NUM_ASCII_CHARS + 1);

    localparam logic [RES_W-1:0] U_MAX     = RES_W'((1 << I_U_NUM_BITS) - 1);
    localparam logic [CNT_W-1:0] MAX_CHARS = CNT_W'(I_A_NUM_ASCII_CHARS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT,
        S_DISCARD,
        S_ERR
    } state_t;

    state_t state;
    state_t state_n;

    // Token being assembled
    logic [I_A_NUM_BITS-1:0] sr;
    logic [ACC_W-1:0]        acc;
    logic [CNT_W-1:0]        count;
    logic                    nondigit;
    logic                    ovf;

    // Byte classification
    logic is_term;
    logic is_print;
    logic is_digit;
    logic accept;

    always_comb begin
        is_term  = (i_byte == 8'h20) || (i_byte == 8'h0A) || (i_byte == 8'h0D);
        is_print = (i_byte >= 8'h21) && (i_byte <= 8'h7E);
        is_digit = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    end

    assign accept = i_valid && o_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values that existed before the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and handshake/pulse outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first. Any path that
    // misses an assignment would otherwise infer a latch.
    always_comb begin
        state_n = state;
        o_ready = 1'b0;
        o_rdy   = 1'b0;
        o_err   = 1'b0;

        // Gate the outputs with reset. This keeps o_ready low and blocks any
        // pulse during reset, before the state register has been cleared.
        if (!i_reset) begin
            o_ready = (state != S_EMIT) && (state != S_ERR);
            o_rdy   = (state == S_EMIT);
            o_err   = (state == S_ERR);
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        state_n = S_COLLECT;
                    end else if (!is_term) begin
                        state_n = S_DISCARD;
                    end
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (is_term) begin
                        state_n = S_EMIT;
                    end else if (!is_print || (count >= MAX_CHARS)) begin
                        state_n = S_DISCARD;
                    end
                end
            end
            S_EMIT:    state_n = S_IDLE;
            S_DISCARD: begin
                if (accept && is_term) begin
                    state_n = S_ERR;
                end
            end
            S_ERR:     state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Packing and numeric decode of the next character
    // -----------------------------------------------------------------------
    logic                    append;
    logic                    emit_load;
    logic [I_A_NUM_BITS-1:0] sr_base;
    logic [ACC_W-1:0]        acc_base;
    logic                    ovf_base;
    logic                    nondigit_base;
    logic [RES_W-1:0]        prod;
    logic [I_A_NUM_BITS-1:0] sr_nxt;
    logic [ACC_W-1:0]        acc_nxt;
    logic                    ovf_nxt;
    logic                    nondigit_nxt;
    logic [CNT_W-1:0]        count_nxt;

    always_comb begin
        append    = accept && is_print &&
                    ((state == S_IDLE) || ((state == S_COLLECT) && (count < MAX_CHARS)));
        emit_load = accept && is_term && (state == S_COLLECT);

        // The first character of a token starts from a clean slate. This
        // holds no matter what the registers contain.
        sr_base       = (state == S_IDLE) ? '0   : sr;
        acc_base      = (state == S_IDLE) ? '0   : acc;
        ovf_base      = (state == S_IDLE) ? 1'b0 : ovf;
        nondigit_base = (state == S_IDLE) ? 1'b0 : nondigit;
        count_nxt     = (state == S_IDLE) ? CNT_W'(1) : count + CNT_W'(1);

        sr_nxt        = {sr_base[I_A_NUM_BITS-9:0], i_byte};
        prod          = RES_W'(acc_base) * RES_W'(10) + RES_W'(i_byte[3:0]);
        acc_nxt       = acc_base;
        ovf_nxt       = ovf_base;
        nondigit_nxt  = nondigit_base | !is_digit;

        // Once ovf is set, the accumulator is frozen. The flag is sticky
        // until the token ends.
        if (is_digit && !ovf_base) begin
            if (prod > U_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = prod[ACC_W-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers and held token outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sr        <= '0;
            acc       <= '0;
            count     <= '0;
            nondigit  <= 1'b0;
            ovf       <= 1'b0;
            o_a       <= '0;
            o_u       <= '0;
            o_u_valid <= 1'b0;
        end else begin
            if ((state == S_EMIT) || (state == S_ERR)) begin
                sr       <= '0;
                acc      <= '0;
                count    <= '0;
                nondigit <= 1'b0;
                ovf      <= 1'b0;
            end else if (append) begin
                sr       <= sr_nxt;
                acc      <= acc_nxt;
                count    <= count_nxt;
                nondigit <= nondigit_nxt;
                ovf      <= ovf_nxt;
            end

            // The outputs are loaded as EMIT is entered. They are therefore
            // valid in the same cycle as the o_rdy pulse.
            if (emit_load) begin
                o_a <= sr;
                if (!nondigit && !ovf) begin
                    o_u       <= acc[I_U_NUM_BITS-1:0];
                    o_u_valid <= 1'b1;
                end else begin
                    o_u       <= '0;
                    o_u_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shop_cmd_assembler.sv
// ---------------------------------------------------------------------------
// tb_shop_cmd_assembler
//
// Directed testbench for shop_cmd_assembler. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge.
//
// A passive monitor records every o_rdy/o_err pulse, the token captured with
// each o_rdy, and the cycles in which o_ready is low.
// ---------------------------------------------------------------------------
module tb_shop_cmd_assembler;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [7:0]  i_byte;
    logic        o_ready;
    logic        o_rdy;
    logic [55:0] o_a;
    logic [3:0]  o_u;
    logic        o_u_valid;
    logic        o_err;

    shop_cmd_assembler dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_byte    (i_byte),
        .o_ready   (o_ready),
        .o_rdy     (o_rdy),
        .o_a       (o_a),
        .o_u       (o_u),
        .o_u_valid (o_u_valid),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int timeouts = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    int          cyc       = 0;
    int          rdy_cnt   = 0;
    int          err_cnt   = 0;
    int          low_cnt   = 0;
    int          both_cnt  = 0;
    logic [55:0] cap_a   [0:31];
    int          cap_cyc [0:31];

    always @(negedge i_clk) begin
        cyc++;
        if (o_rdy && o_err) both_cnt++;
        if (o_err) err_cnt++;
        if (!o_ready && !i_reset) low_cnt++;
        if (o_rdy) begin
            if (rdy_cnt < 32) begin
                cap_a[rdy_cnt]   = o_a;
                cap_cyc[rdy_cnt] = cyc;
            end
            rdy_cnt++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    // Present one byte and hold it until it is accepted. The task returns
    // just after the accepting rising edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_byte  = b;
        while (!o_ready && n < 8) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) timeouts++;
        @(posedge i_clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // Move to the cycle after the last accepted byte, which is the EMIT/ERR
    // cycle when that byte was a terminator, and stop driving.
    task automatic end_stream();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    int rdy0, err0, low0;

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_byte  = 8'h00;
        repeat (3) @(negedge i_clk);
        check("rst_ready",   o_ready,   0);
        check("rst_rdy",     o_rdy,     0);
        check("rst_err",     o_err,     0);
        check("rst_a",       o_a,       0);
        check("rst_u",       o_u,       0);
        check("rst_u_valid", o_u_valid, 0);
        i_reset = 1'b0;
        #1;
        check("post_rst_ready", o_ready, 1);

        // 1: "Login\n"; pulse exactly one cycle after the terminator
        send_str("Login\n");
        end_stream();
        check("t1_rdy",     o_rdy,     1);
        check("t1_a",       o_a,       56'h00_00_4C_6F_67_69_6E);
        check("t1_u_valid", o_u_valid, 0);
        check("t1_ready",   o_ready,   0);
        @(negedge i_clk);
        check("t1_rdy_one_cycle", o_rdy, 0);
        idle(1);

        // 2: "12 " is a valid number; "16\n" overflows 4 bits; "15\r" is
        // the largest value that fits
        send_str("12 ");
        end_stream();
        check("t2_rdy",     o_rdy,     1);
        check("t2_u",       o_u,       4'd12);
        check("t2_u_valid", o_u_valid, 1);
        check("t2_a",       o_a,       56'h00_00_00_00_00_31_32);
        idle(2);
        check("t2_u_hold",  o_u,       4'd12);
        send_str("16\n");
        end_stream();
        check("t2_ovf_rdy",     o_rdy,     1);
        check("t2_ovf_u",       o_u,       0);
        check("t2_ovf_u_valid", o_u_valid, 0);
        check("t2_ovf_a",       o_a,       56'h3136);
        idle(1);
        send_str("15\r");
        end_stream();
        check("t2_max_u",       o_u,       4'd15);
        check("t2_max_u_valid", o_u_valid, 1);
        idle(2);

        // 3: leading spaces never produce a pulse
        rdy0 = rdy_cnt;
        send_str("  Buy\n");
        end_stream();
        check("t3_rdy", o_rdy, 1);
        check("t3_a",   o_a,   56'h0000000042_7579);
        idle(2);
        check("t3_pulses", rdy_cnt - rdy0, 1);

        // 4: an 8-char token is discarded; 7 chars fits
        rdy0 = rdy_cnt;
        err0 = err_cnt;
        send_str("AddItemX\n");
        end_stream();
        check("t4_err",    o_err, 1);
        check("t4_no_rdy", o_rdy, 0);
        check("t4_a_kept", o_a,   56'h0000000042_7579);
        @(negedge i_clk);
        check("t4_err_one_cycle", o_err, 0);
        idle(1);
        send_str("AddItem\n");
        end_stream();
        check("t4_rdy", o_rdy, 1);
        check("t4_a",   o_a,   56'h41_64_64_49_74_65_6D);
        idle(2);
        check("t4_pulses", rdy_cnt - rdy0, 1);
        check("t4_errs",   err_cnt - err0, 1);

        // Illegal byte (0x01) inside a token is discarded with o_err
        err0 = err_cnt;
        send(8'h41);
        send(8'h01);
        send(8'h42);
        send(8'h0A);
        end_stream();
        check("ill_err",    o_err, 1);
        check("ill_a_kept", o_a,   56'h41_64_64_49_74_65_6D);
        idle(2);
        check("ill_errs",   err_cnt - err0, 1);

        // 5: continuous valid; the 'C' waits through the first EMIT
        rdy0 = rdy_cnt;
        low0 = low_cnt;
        send_str("Adm Cmd\n");
        end_stream();
        idle(2);
        check("t5_pulses",     rdy_cnt - rdy0, 2);
        check("t5_ready_lows", low_cnt - low0, 2);
        check("t5_a0",         cap_a[rdy0],     56'h41_64_6D);
        check("t5_a1",         cap_a[rdy0 + 1], 56'h43_6D_64);
        check("t5_gap",        cap_cyc[rdy0 + 1] - cap_cyc[rdy0], 5);

        // 6: reset in the middle of "Del" drops the partial token
        rdy0 = rdy_cnt;
        send_str("Del");
        @(negedge i_clk);
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
        check("t6_rst_a",     o_a,     0);
        check("t6_rst_rdy",   o_rdy,   0);
        check("t6_rst_ready", o_ready, 0);
        i_reset = 1'b0;
        send_str("Buy\n");
        end_stream();
        check("t6_rdy", o_rdy, 1);
        check("t6_a",   o_a,   56'h0000000042_7579);
        idle(2);
        check("t6_pulses", rdy_cnt - rdy0, 1);

        check("rdy_err_exclusive", both_cnt, 0);
        check("accept_timeouts",   timeouts, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
